// File: rtl/exp6_unidade_controle.sv
// exp6_unidade_controle: Moore FSM sequencing the memory-game datapath over growing rounds.
// Optional play timeout (counter + FIM_TIMEOUT state) enabled by defining TIMEOUT_EN.
module exp6_unidade_controle #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  input  logic       fimR,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraRod,
  output logic       contaRod,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTOU    = 4'hA,
`ifdef TIMEOUT_EN
    FIM_TIMEOUT    = 4'hC,
`endif
    FIM_ERROU      = 4'hE
  } estado_t;
  estado_t estado, prox, espera_prox, fim_prox;
`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] cnt;
  logic tmo;
  assign tmo = cnt == TW'(TIMEOUT_CYCLES - 1);
  // Counter leaves ESPERA_JOGADA together with the state, so every re-entry starts at 0.
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (estado == ESPERA_JOGADA && !jogada && !tmo) ? cnt + 1'b1 : '0;
  assign espera_prox = jogada ? REGISTRA : tmo ? FIM_TIMEOUT : ESPERA_JOGADA;
  assign timeout = estado == FIM_TIMEOUT;
`else
  assign espera_prox = jogada ? REGISTRA : ESPERA_JOGADA;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset)
    if (!reset) estado <= INICIAL;
    else estado <= prox;
  assign fim_prox = iniciar ? PREPARACAO : estado;
  always_comb begin
    prox = INICIAL;
    case (estado)
      INICIAL, FIM_ACERTOU, FIM_ERROU: prox = fim_prox;
`ifdef TIMEOUT_EN
      FIM_TIMEOUT:    prox = fim_prox;
`endif
      PREPARACAO:     prox = INICIA_RODADA;
      INICIA_RODADA:  prox = ESPERA_JOGADA;
      ESPERA_JOGADA:  prox = espera_prox;
      REGISTRA:       prox = COMPARA;
      COMPARA:        prox = !igual ? FIM_ERROU : !fimC ? PROXIMA_JOGADA :
                             !fimR ? PROXIMA_RODADA : FIM_ACERTOU;
      PROXIMA_JOGADA: prox = ESPERA_JOGADA;
      PROXIMA_RODADA: prox = INICIA_RODADA;
      default:        prox = INICIAL;
    endcase
  end
  assign zeraC     = estado == PREPARACAO || estado == INICIA_RODADA;
  assign contaC    = estado == PROXIMA_JOGADA;
  assign zeraR     = estado == PREPARACAO;
  assign registraR = estado == REGISTRA;
  assign zeraRod   = estado == PREPARACAO;
  assign contaRod  = estado == PROXIMA_RODADA;
  assign acertou   = estado == FIM_ACERTOU;
  assign errou     = estado == FIM_ERROU;
  assign pronto    = acertou || errou || timeout;
  assign db_estado = estado;
endmodule
